// File: rtl/cacheline_adapter.sv
// Line-to-burst adapter: a 256-bit line request from the arbiter becomes a
// 4-beat 64-bit burst on the memory port, followed by a one-cycle line response.
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  line_address_i,
    input  logic         line_read_i,
    input  logic         line_write_i,
    input  logic [255:0] line_wdata_i,
    output logic [255:0] line_rdata_o,
    output logic         line_resp_o,
    output logic [31:0]  pmem_address_o,
    output logic         pmem_read_o,
    output logic         pmem_write_o,
    output logic [63:0]  pmem_wdata_o,
    input  logic [63:0]  pmem_rdata_i,
    input  logic         pmem_resp_i
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_BURST = 3'd1;
    localparam logic [2:0] RD_DONE  = 3'd2;
    localparam logic [2:0] WR_BURST = 3'd3;
    localparam logic [2:0] WR_DONE  = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wline_q, wline_d;
    logic [255:0] rline_q, rline_d;
    logic [63:0]  wbeat [4];

    // The line is always burst-aligned, so the low address bits never matter.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^line_address_i[4:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wbeat
            assign wbeat[gi] = wline_q[64*gi +: 64];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            IDLE: begin
                if (line_read_i) begin
                    addr_d  = {line_address_i[31:5], 5'b0};
                    cnt_d   = 2'd0;
                    state_d = RD_BURST;
                end else if (line_write_i) begin
                    addr_d  = {line_address_i[31:5], 5'b0};
                    wline_d = line_wdata_i;
                    cnt_d   = 2'd0;
                    state_d = WR_BURST;
                end
            end
            RD_BURST: begin
                if (pmem_resp_i) begin
                    rline_d[64*cnt_q +: 64] = pmem_rdata_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = RD_DONE;
                    end
                end
            end
            WR_BURST: begin
                if (pmem_resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = WR_DONE;
                    end
                end
            end
            RD_DONE:  state_d = IDLE;
            WR_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // All outputs decode registered state only.
    assign line_rdata_o   = rline_q;
    assign line_resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
    assign pmem_read_o    = (state_q == RD_BURST);
    assign pmem_write_o   = (state_q == WR_BURST);
    assign pmem_address_o = (pmem_read_o || pmem_write_o) ? addr_q : 32'd0;
    assign pmem_wdata_o   = pmem_write_o ? wbeat[cnt_q] : 64'd0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus pushes expected line responses,
// a negedge monitor pops and checks them whenever line_resp_o is seen.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  line_address_i;
    logic         line_read_i;
    logic         line_write_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  pmem_address_o;
    logic         pmem_read_o;
    logic         pmem_write_o;
    logic [63:0]  pmem_wdata_o;
    logic [63:0]  pmem_rdata_i;
    logic         pmem_resp_i;

    cacheline_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .line_address_i (line_address_i),
        .line_read_i    (line_read_i),
        .line_write_i   (line_write_i),
        .line_wdata_i   (line_wdata_i),
        .line_rdata_o   (line_rdata_o),
        .line_resp_o    (line_resp_o),
        .pmem_address_o (pmem_address_o),
        .pmem_read_o    (pmem_read_o),
        .pmem_write_o   (pmem_write_o),
        .pmem_wdata_o   (pmem_wdata_o),
        .pmem_rdata_i   (pmem_rdata_i),
        .pmem_resp_i    (pmem_resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [255:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    localparam logic [255:0] RL1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [255:0] RL2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                    64'hA5A5_5A5A_F00D_CAFE, 64'h0000_0001_8000_0000};
    localparam logic [255:0] WL1 = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                                    64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    localparam logic [255:0] RL3 = {64'h3333_AAAA_3333_AAAA, 64'h2222_BBBB_2222_BBBB,
                                    64'h1111_CCCC_1111_CCCC, 64'h0000_DDDD_0000_DDDD};
    localparam logic [255:0] WL2 = {64'h7777_7777_0000_0004, 64'h6666_6666_0000_0003,
                                    64'h5555_5555_0000_0002, 64'h4444_4444_0000_0001};
    localparam logic [255:0] RL4 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                                    64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rdata"}, line_rdata_o, 256'd0);
        chk({name, "_outs"}, {line_resp_o, pmem_read_o, pmem_write_o, pmem_address_o, pmem_wdata_o}, 256'd0);
    endtask

    // Runs one burst; mask bit r drives pmem_resp_i in relative cycle r (request cycle is 0).
    task automatic burst(input bit wr, input logic [31:0] addr, input logic [31:0] exp_paddr,
                         input logic [255:0] line, input logic [15:0] mask,
                         input int exp_rel, input logic [255:0] exp_rdata);
        int c0;
        int nb;
        c0 = cyc;
        chk("idle_before", {line_resp_o, pmem_read_o, pmem_write_o}, 256'd0);
        line_address_i = addr;
        if (wr) begin
            line_write_i = 1'b1;
            line_wdata_i = line;
        end else begin
            line_read_i = 1'b1;
        end
        step();
        if (wr) begin
            line_write_i = 1'b0;
            line_wdata_i = ~line;
        end else begin
            line_read_i = 1'b0;
        end
        line_address_i = ~addr;
        nb = 0;
        for (int r = 1; r < 16 && nb < 4; r++) begin
            chk("req", {pmem_read_o, pmem_write_o}, wr ? 256'd1 : 256'd2);
            chk("paddr", pmem_address_o, exp_paddr);
            chk("wdata", pmem_wdata_o, wr ? line[64*nb +: 64] : 64'd0);
            chk("resp_early", line_resp_o, 256'd0);
            if (mask[r]) begin
                pmem_resp_i  = 1'b1;
                pmem_rdata_i = wr ? 64'hBAD0_BAD0_BAD0_BAD0 : line[64*nb +: 64];
                nb++;
            end else begin
                pmem_resp_i  = 1'b0;
                pmem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            step();
        end
        pmem_resp_i = 1'b0;
        q.push_back('{c0 + exp_rel, exp_rdata});
        chk("req_drop", {pmem_read_o, pmem_write_o, pmem_address_o, pmem_wdata_o}, 256'd0);
        step();
        chk("idle_after", {line_resp_o, pmem_read_o, pmem_write_o}, 256'd0);
        $display("[TB] %s addr=%h started cycle %0d, expected resp cycle %0d",
                 wr ? "write" : "read", addr, c0, c0 + exp_rel);
    endtask

    // Monitor: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (line_resp_o) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL resp_unexpected at cycle %0d: got pulse required none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_rdata", line_rdata_o, e.data);
                $display("[TB] resp at cycle %0d rdata=%h", cyc, line_rdata_o);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        line_address_i = '0;
        line_read_i    = 1'b0;
        line_write_i   = 1'b0;
        line_wdata_i   = '0;
        pmem_rdata_i   = '0;
        pmem_resp_i    = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        // Contiguous read, gapped read, write with late accepts
        burst(1'b0, 32'h0000_1234, 32'h0000_1220, RL1, 16'h001E, 5, RL1);
        burst(1'b0, 32'h8000_005F, 32'h8000_0040, RL2, 16'h0264, 10, RL2);
        burst(1'b1, 32'h0000_ABCF, 32'h0000_ABC0, WL1, 16'h0078, 7, RL2);

        // Read and write together: read first, write still pending afterwards
        line_wdata_i = WL2;
        line_write_i = 1'b1;
        burst(1'b0, 32'h1000_0020, 32'h1000_0020, RL3, 16'h001E, 5, RL3);
        burst(1'b1, 32'h2000_0007, 32'h2000_0000, WL2, 16'h001E, 5, RL3);

        // Reset after two beats of a read, then stray beats while idle
        line_address_i = 32'h3000_0000;
        line_read_i    = 1'b1;
        step();
        line_read_i  = 1'b0;
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = 64'h9999_9999_9999_9999;
        step();
        step();
        pmem_resp_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("mid_reset");
        for (int i = 0; i < 2; i++) begin
            pmem_resp_i  = 1'b1;
            pmem_rdata_i = 64'h7777_7777_7777_7777;
            step();
            chk_all_zero("stray_beat");
        end
        pmem_resp_i = 1'b0;
        step();
        burst(1'b0, 32'h3000_0010, 32'h3000_0000, RL4, 16'h001E, 5, RL4);

        // Back-to-back read then write
        burst(1'b0, 32'h4000_0040, 32'h4000_0040, RL1, 16'h001E, 5, RL1);
        burst(1'b1, 32'h5000_0060, 32'h5000_0060, WL1, 16'h001E, 5, RL1);

        repeat (5) step();
        chk("pending_resps", q.size(), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
